// File: rtl/instruction_fetch.sv
// Purpose: fetches 9-bit instruction words (and a trailing immediate for loads) from a sync ROM and launches them on start.
// Latency: start rises 2 cycles after FETCH for plain instructions, 4 cycles for load-immediate instructions.
// Backpressure: holds start in EXEC until a fresh rising edge of done; run low parks the FSM in IDLE after the current instruction.
module instruction_fetch #(
    parameter int         ADDR_W      = 5,
    parameter logic [2:0] LOAD_OPCODE = 3'b001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [8:0]        mem_rdata,
    output logic [8:0]        instruction,
    output logic [7:0]        imm_data,
    output logic              start,
    input  logic              done,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        fetch_state
);

    typedef enum logic [2:0] {
        IDLE        = 3'b000,
        FETCH       = 3'b001,
        CAPTURE     = 3'b010,
        IMM_FETCH   = 3'b011,
        IMM_CAPTURE = 3'b100,
        EXEC        = 3'b101
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t state;
    logic   done_q;
    logic   done_rise;

    // Only a 0->1 transition of done completes an instruction, so a level
    // left over from the previous instruction cannot retire the next one.
    assign done_rise   = done & ~done_q;

    // The ROM is always addressed by the program counter.
    assign mem_addr    = pc;
    assign fetch_state = state;

    // Register done every cycle for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done;
        end
    end

    // Fetch FSM; mem_rd and start are registered, set on the transition
    // into the state that owns them so they are high for that whole state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            instruction <= '0;
            imm_data    <= '0;
            start       <= 1'b0;
            mem_rd      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    start  <= 1'b0;
                    mem_rd <= 1'b0;
                    if (run) begin
                        state  <= FETCH;
                        mem_rd <= 1'b1;
                    end
                end

                FETCH: begin
                    // ROM returns the word at pc during the next cycle.
                    state  <= CAPTURE;
                    mem_rd <= 1'b0;
                end

                CAPTURE: begin
                    instruction <= mem_rdata;
                    pc          <= pc + PC_ONE;
                    if (mem_rdata[8:6] == LOAD_OPCODE) begin
                        // Immediate lives at the already-incremented pc.
                        state  <= IMM_FETCH;
                        mem_rd <= 1'b1;
                    end else begin
                        state <= EXEC;
                        start <= 1'b1;
                    end
                end

                IMM_FETCH: begin
                    state  <= IMM_CAPTURE;
                    mem_rd <= 1'b0;
                end

                IMM_CAPTURE: begin
                    imm_data <= mem_rdata[7:0];
                    pc       <= pc + PC_ONE;
                    state    <= EXEC;
                    start    <= 1'b1;
                end

                EXEC: begin
                    if (done_rise) begin
                        start <= 1'b0;
                        if (run) begin
                            state  <= FETCH;
                            mem_rd <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    start  <= 1'b0;
                    mem_rd <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              run;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [8:0]        mem_rdata;
    logic [8:0]        instruction;
    logic [7:0]        imm_data;
    logic              start;
    logic              done;
    logic [ADDR_W-1:0] pc;
    logic [2:0]        fetch_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] rom [0:(1<<ADDR_W)-1];

    instruction_fetch #(.ADDR_W(ADDR_W), .LOAD_OPCODE(3'b001)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .instruction (instruction),
        .imm_data    (imm_data),
        .start       (start),
        .done        (done),
        .pc          (pc),
        .fetch_state (fetch_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous program ROM: data valid the cycle after mem_rd.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= rom[mem_addr];
    end

    typedef struct {
        logic       run;
        logic       done;
        logic [2:0] st;
        logic [4:0] pc;
        logic [8:0] ins;
        logic [7:0] imm;
        logic       start;
        logic       rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] st, input logic [4:0] p,
                           input logic [8:0] ins, input logic [7:0] imm,
                           input logic stt, input logic rd);
        chk({tag, ".state"}, 32'(fetch_state), 32'(st));
        chk({tag, ".pc"}, 32'(pc), 32'(p));
        chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(p));
        chk({tag, ".instruction"}, 32'(instruction), 32'(ins));
        chk({tag, ".imm_data"}, 32'(imm_data), 32'(imm));
        chk({tag, ".start"}, 32'(start), 32'(stt));
        chk({tag, ".mem_rd"}, 32'(mem_rd), 32'(rd));
    endtask

    // Drive inputs on the falling edge, then sample just after the rising edge.
    task automatic step(input logic r, input logic d);
        @(negedge clk);
        run  = r;
        done = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1<<ADDR_W); i++) rom[i] = 9'h000;
        rom[0]  = 9'b000_001_010;   // 0x00A, plain
        rom[1]  = 9'b001_011_000;   // 0x058, load
        rom[2]  = 9'h05A;           // immediate
        rom[3]  = 9'h0C3;           // plain
        rom[31] = 9'h047;           // load at last address, immediate wraps to 0
        mem_rdata = 9'h000;

        // run, done | state, pc, instruction, imm, start, mem_rd (after the edge)
        // Plain instruction at address 0.
        vecs.push_back('{1'b1, 1'b0, 3'd1, 5'd0, 9'h000, 8'h00, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 3'd2, 5'd0, 9'h000, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'd5, 5'd1, 9'h00A, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'd5, 5'd1, 9'h00A, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'd1, 5'd1, 9'h00A, 8'h00, 1'b0, 1'b1});
        // Load at address 1, run dropped during IMM_FETCH.
        vecs.push_back('{1'b1, 1'b0, 3'd2, 5'd1, 9'h00A, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'd3, 5'd2, 9'h058, 8'h00, 1'b0, 1'b1});
        vecs.push_back('{1'b0, 1'b0, 3'd4, 5'd2, 9'h058, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 3'd5, 5'd3, 9'h058, 8'h5A, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 3'd5, 5'd3, 9'h058, 8'h5A, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd0, 5'd3, 9'h058, 8'h5A, 1'b0, 1'b0});
        // done edges in IDLE are ignored.
        vecs.push_back('{1'b0, 1'b0, 3'd0, 5'd3, 9'h058, 8'h5A, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd0, 5'd3, 9'h058, 8'h5A, 1'b0, 1'b0});
        // Resume at 3 with done stuck high: stale level must not complete EXEC.
        vecs.push_back('{1'b1, 1'b1, 3'd1, 5'd3, 9'h058, 8'h5A, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 3'd2, 5'd3, 9'h058, 8'h5A, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'd5, 5'd4, 9'h0C3, 8'h5A, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'd5, 5'd4, 9'h0C3, 8'h5A, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'd5, 5'd4, 9'h0C3, 8'h5A, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'd1, 5'd4, 9'h0C3, 8'h5A, 1'b0, 1'b1});
        // Plain at 4 with run low, parks at pc=5.
        vecs.push_back('{1'b0, 1'b0, 3'd2, 5'd4, 9'h0C3, 8'h5A, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 3'd5, 5'd5, 9'h000, 8'h5A, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'd0, 5'd5, 9'h000, 8'h5A, 1'b0, 1'b0});

        // Reset state.
        rst  = 1'b1;
        run  = 1'b0;
        done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 3'd0, 5'd0, 9'h000, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].run, vecs[i].done);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].pc, vecs[i].ins,
                    vecs[i].imm, vecs[i].start, vecs[i].rd);
        end

        // Walk plain instructions at 5..30 to bring pc to the last address.
        step(1'b1, 1'b0);
        for (int k = 5; k <= 30; k++) begin
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            chk($sformatf("walk%0d.start", k), 32'(start), 32'd1);
            step(1'b1, 1'b1);
        end
        chk_all("wrap.fetch31", 3'd1, 5'd31, 9'h000, 8'h5A, 1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk_all("wrap.immfetch0", 3'd3, 5'd0, 9'h047, 8'h5A, 1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk_all("wrap.exec", 3'd5, 5'd1, 9'h047, 8'h0A, 1'b1, 1'b0);

        // Asynchronous reset in EXEC clears everything before the next edge.
        #1;
        rst = 1'b1;
        #1;
        chk_all("async_rst", 3'd0, 5'd0, 9'h000, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        done = 1'b0;
        step(1'b0, 1'b0);
        chk_all("post_rst_idle", 3'd0, 5'd0, 9'h000, 8'h00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Upstream stage of the 9-bit instruction control circuit.
- Fetches instruction words from a synchronous program ROM using a program counter, and holds the current word on `instruction`.
- For load-immediate opcodes, fetches the following word as the immediate operand.
- Raises `start` and holds it until the control circuit reports completion on `done`, then moves on to the next instruction.

Parameters:
- ADDR_W, 5: program counter and ROM address width. The PC wraps modulo 2^ADDR_W.
- LOAD_OPCODE, 3'b001: value of instruction[8:6] that identifies a load-immediate instruction, which carries a trailing immediate word.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- run  input  1  level enable. While high, the block fetches and executes continuously.
- mem_addr  output  ADDR_W  ROM read address. Always equal to pc.
- mem_rd  output  1  ROM read strobe.
- mem_rdata  input  9  ROM read data, valid the cycle after mem_rd.
- instruction  output  9  instruction register; drives the control circuit's instruction input.
- imm_data  output  8  immediate register, equal to the low 8 bits of the immediate word.
- start  output  1  registered execute request to the control circuit.
- done  input  1  completion flag from the control circuit. May stay high across cycles.
- pc  output  ADDR_W  current program counter.
- fetch_state  output  3  current FSM state encoding, for debug.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - pc=0, instruction=0, imm_data=0, start=0, mem_rd=0, done_q=0.
  - State=IDLE (3'b000).
  - Reset asserted mid-operation aborts everything at once. No partial update survives.
- States and encodings: IDLE=000, FETCH=001, CAPTURE=010, IMM_FETCH=011, IMM_CAPTURE=100, EXEC=101.
- IDLE: all strobes low. Go to FETCH when run=1.
- FETCH: mem_rd=1, mem_addr=pc. Always go to CAPTURE.
- CAPTURE:
  - instruction <= mem_rdata; pc <= pc+1.
  - If mem_rdata[8:6]==LOAD_OPCODE, go to IMM_FETCH. Otherwise go to EXEC.
- IMM_FETCH: mem_rd=1, using the already-incremented pc. Go to IMM_CAPTURE.
- IMM_CAPTURE: imm_data <= mem_rdata[7:0]; pc <= pc+1. Go to EXEC.
- EXEC:
  - start=1, registered: high from the first EXEC cycle and held for the whole of EXEC.
  - Leave EXEC on a rising edge of done (done=1 and done_q=0, where done_q is done registered every cycle).
  - On leaving: if run=1, go to FETCH; otherwise go to IDLE. start=0 from the next cycle.
- start is 0 in every state other than EXEC.
- Stale done:
  - A done level carried over from the previous instruction never completes a new EXEC; only a fresh 0->1 edge does.
  - done edges outside EXEC are ignored. They must not change state.
- run deasserted mid-instruction: the current instruction completes (fetch, immediate, EXEC). The FSM then parks in IDLE with pc pointing at the next instruction.
- PC wrap: pc = 2^ADDR_W-1 increments to 0. This includes an immediate word sitting at the last address, whose instruction is then fetched from address 0 next.
- Latency:
  - Non-load instruction: start rises exactly 2 cycles after FETCH is entered.
  - Load-immediate instruction: start rises 4 cycles after FETCH is entered.
- instruction and imm_data hold their values from CAPTURE/IMM_CAPTURE until the next capture. A non-load instruction leaves imm_data unchanged.
- mem_rdata is sampled only in CAPTURE and IMM_CAPTURE.

Test Plan:
1. Reset then run=1, ROM[0]=9'b000_001_010 (non-load) -> mem_rd high in cycle 1; instruction=0x00A and pc=1 after cycle 2; start=1 from cycle 3; pulse done -> start=0 next cycle, FETCH at addr 1.
2. ROM[1]=9'b001_011_000 (LOAD_OPCODE), ROM[2]=9'h05A -> instruction=0x058, imm_data=0x5A, pc=3; start rises 4 cycles after FETCH.
3. Hold done=1 continuously from the previous instruction into the next EXEC -> start stays high; only done falling and then rising completes the instruction.
4. Drop run during IMM_FETCH -> immediate still captured, EXEC completes on a done edge, FSM goes to IDLE with pc=3; run=1 again resumes at addr 3.
5. ADDR_W=5, pc=31 holding a load opcode -> immediate read from addr 0; pc=1 afterwards.
6. Assert rst while in EXEC with start=1 -> start, pc, instruction, imm_data all 0 and FSM in IDLE before the next clock edge.
